// File: rtl/bg_pixel_shifter_if.sv
// Pixel push link between the background fetcher (master) and the pixel shifter FIFO (slave).
typedef struct packed {
  logic [1:0] color;
} ppu_pixel_t;

interface bg_pixel_shifter_if #(
  parameter int DEPTH = 16
);
  logic                   bg_push_en;
  ppu_pixel_t             bg_push_px;
  logic                   bg_fifo_full;
  logic                   bg_fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output bg_push_en, bg_push_px,
    input  bg_fifo_full, bg_fifo_empty, fifo_count
  );

  modport slave (
    input  bg_push_en, bg_push_px,
    output bg_fifo_full, bg_fifo_empty, fifo_count
  );
endinterface

// File: rtl/bg_pixel_shifter.sv
// Background pixel FIFO plus per-dot shifter: drops SCX fine-scroll pixels, maps colour
// indices through BGP and emits one shade per dot for a SCREEN_W-wide line.
module bg_pixel_shifter #(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = 160
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dot_en,
  input  logic                flush,
  input  logic                line_start,
  input  logic [2:0]          scx_fine,
  input  logic [7:0]          bgp,
  bg_pixel_shifter_if.slave   push,
  output logic                pixel_valid,
  output logic [7:0]          pixel_x,
  output logic [1:0]          pixel_shade,
  output logic                line_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    LAST_COL = 8'(SCREEN_W - 1);

  typedef enum logic [1:0] {IDLE, DISCARD, SHIFT, DONE} state_t;

  state_t        state_q, state_nxt;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          full_q, empty_q;
  logic [2:0]    disc, disc_nxt;
  logic [7:0]    col, col_nxt;
  logic          pop, push_ok;
  logic [1:0]    rd_color;

  logic          vld_p1, vld_nxt;
  logic [7:0]    x_p1, x_nxt;
  logic [1:0]    shade_p1, shade_nxt;
  logic          done_p1, done_nxt;

  function automatic logic [1:0] bgp_map(input logic [7:0] pal, input logic [1:0] c);
    return pal[{c, 1'b0} +: 2];
  endfunction

  // A flush cycle swallows both the push and the pop so the FIFO restarts cleanly.
  assign pop      = dot_en && !empty_q && !flush &&
                    ((state_q == DISCARD) || (state_q == SHIFT));
  assign push_ok  = push.bg_push_en && (!full_q || pop) && !flush;
  assign rd_color = mem[rd_ptr];

  always_comb begin
    count_nxt  = count;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push_ok) wr_ptr_nxt = wr_ptr + 1'b1;
      if (pop)     rd_ptr_nxt = rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state_q;
    disc_nxt  = disc;
    col_nxt   = col;
    vld_nxt   = 1'b0;
    done_nxt  = 1'b0;
    x_nxt     = x_p1;
    shade_nxt = shade_p1;
    case (state_q)
      IDLE: begin
        if (dot_en && line_start) begin
          disc_nxt  = scx_fine;
          col_nxt   = '0;
          x_nxt     = '0;
          state_nxt = (scx_fine != 3'd0) ? DISCARD : SHIFT;
        end
      end
      DISCARD: begin
        if (pop) begin
          disc_nxt = disc - 1'b1;
          if (disc == 3'd1) state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (pop) begin
          vld_nxt   = 1'b1;
          x_nxt     = col;
          shade_nxt = bgp_map(bgp, rd_color);
          col_nxt   = col + 1'b1;
          if (col == LAST_COL) state_nxt = DONE;
        end
      end
      DONE: begin
        if (dot_en) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is never reset; only the pointers/count decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push.bg_push_px.color;
  end

  // Output stage p1: registered state, FIFO flags and pixel strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      disc     <= '0;
      col      <= '0;
      vld_p1   <= 1'b0;
      x_p1     <= '0;
      shade_p1 <= '0;
      done_p1  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      full_q   <= (count_nxt == FULL_CNT);
      empty_q  <= (count_nxt == '0);
      disc     <= disc_nxt;
      col      <= col_nxt;
      vld_p1   <= vld_nxt;
      x_p1     <= x_nxt;
      shade_p1 <= shade_nxt;
      done_p1  <= done_nxt;
    end
  end

  assign push.bg_fifo_full  = full_q;
  assign push.bg_fifo_empty = empty_q;
  assign push.fifo_count    = count;
  assign pixel_valid        = vld_p1;
  assign pixel_x            = x_p1;
  assign pixel_shade        = shade_p1;
  assign line_done          = done_p1;

  a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= FULL_CNT);
  a_flags_excl:  assert property (@(posedge clk) disable iff (reset) !(full_q && empty_q));

endmodule

// File: tb/tb_bg_pixel_shifter.sv
// Directed bench for bg_pixel_shifter: FIFO vector table plus hand-written line sequences.
module tb_bg_pixel_shifter;
  localparam int DEPTH = 16;

  typedef struct {
    logic       push;
    logic [1:0] color;
    logic       dot;
    logic       flush;
    int         exp_count;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, dot_en, flush, line_start;
  logic [2:0] scx_fine;
  logic [7:0] bgp;
  logic       pixel_valid, line_done;
  logic [7:0] pixel_x;
  logic [1:0] pixel_shade;
  int         checks = 0;
  int         errors = 0;
  vec_t       vecs[22];

  bg_pixel_shifter_if #(.DEPTH(DEPTH)) bus ();

  bg_pixel_shifter #(.DEPTH(DEPTH), .SCREEN_W(160)) dut (
    .clk(clk), .reset(reset), .dot_en(dot_en), .flush(flush), .line_start(line_start),
    .scx_fine(scx_fine), .bgp(bgp), .push(bus.slave), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_shade(pixel_shade), .line_done(line_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input int p, input int c, input int d, input int f,
                               input int cnt, input int fu, input int em);
    vec_t v;
    v.push = (p != 0); v.color = 2'(c); v.dot = (d != 0); v.flush = (f != 0);
    v.exp_count = cnt; v.exp_full = (fu != 0); v.exp_empty = (em != 0);
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; bus.bg_push_en = 1'b0; flush = 1'b0; line_start = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic prefill(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      bus.bg_push_en = 1'b1; bus.bg_push_px.color = 2'((start + i) % 4);
      tick();
    end
    bus.bg_push_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dot_en = 1'b1; flush = 1'b0; line_start = 1'b0;
    scx_fine = 3'd0; bgp = 8'hE4;
    bus.bg_push_en = 1'b0; bus.bg_push_px.color = 2'd0;

    for (int i = 0; i < 16; i++) vecs[i] = mkv(1, i % 4, 1, 0, i + 1, (i == 15) ? 1 : 0, 0);
    vecs[16] = mkv(1, 0, 1, 0, 16, 1, 0);
    vecs[17] = mkv(1, 1, 0, 0, 16, 1, 0);
    vecs[18] = mkv(1, 1, 1, 1, 0, 0, 1);
    vecs[19] = mkv(1, 2, 0, 0, 1, 0, 0);
    vecs[20] = mkv(0, 0, 1, 0, 1, 0, 0);
    vecs[21] = mkv(0, 0, 1, 1, 0, 0, 1);

    tick(); tick();
    chk("reset empty", int'(bus.bg_fifo_empty), 1);
    chk("reset full", int'(bus.bg_fifo_full), 0);
    chk("reset count", int'(bus.fifo_count), 0);
    chk("reset valid", int'(pixel_valid), 0);
    chk("reset line_done", int'(line_done), 0);
    chk("reset pixel_x", int'(pixel_x), 0);
    reset = 1'b0;

    // FIFO fill/drop/flush in IDLE (no pops possible)
    for (int i = 0; i < 22; i++) begin
      bus.bg_push_en = vecs[i].push; bus.bg_push_px.color = vecs[i].color;
      dot_en = vecs[i].dot; flush = vecs[i].flush;
      tick();
      chk($sformatf("vec%0d count", i), int'(bus.fifo_count), vecs[i].exp_count);
      chk($sformatf("vec%0d full", i), int'(bus.bg_fifo_full), int'(vecs[i].exp_full));
      chk($sformatf("vec%0d empty", i), int'(bus.bg_fifo_empty), int'(vecs[i].exp_empty));
    end
    bus.bg_push_en = 1'b0; flush = 1'b0; dot_en = 1'b1;

    // SCX fine discard of 3 pixels, then reset mid-line
    do_reset();
    bgp = 8'hE4;
    prefill(8, 0);
    scx_fine = 3'd3; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("discard%0d valid", k), int'(pixel_valid), 0);
      chk($sformatf("discard%0d count", k), int'(bus.fifo_count), 8 - k);
    end
    tick();
    chk("scx first valid", int'(pixel_valid), 1);
    chk("scx first x", int'(pixel_x), 0);
    chk("scx first shade", int'(pixel_shade), 3);
    tick();
    chk("scx second x", int'(pixel_x), 1);
    chk("scx second shade", int'(pixel_shade), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midline reset count", int'(bus.fifo_count), 0);
    chk("midline reset empty", int'(bus.bg_fifo_empty), 1);
    chk("midline reset valid", int'(pixel_valid), 0);
    begin : no_done_after_reset
      int dn;
      dn = 0;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (line_done) dn++;
      end
      chk("midline reset no line_done", dn, 0);
    end

    // Stall with empty FIFO at x = 40
    begin : stall_test
      int pushed, nx, last_cyc;
      do_reset();
      bgp = 8'hE4; scx_fine = 3'd0;
      prefill(16, 0);
      pushed = 16; nx = 0; last_cyc = 0;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        bus.bg_push_en = (cyc < 24) || (cyc >= 45);
        bus.bg_push_px.color = 2'(pushed % 4);
        tick();
        if (bus.bg_push_en) pushed++;
        if (pixel_valid) begin
          chk("stall x", int'(pixel_x), nx);
          chk("stall shade", int'(pixel_shade), nx % 4);
          if (nx == 40) chk("stall gap", cyc - last_cyc, 7);
          last_cyc = cyc;
          nx++;
        end
      end
      bus.bg_push_en = 1'b0;
      chk("stall total pixels", nx, 54);
    end

    // Full line with SCX 0, BGP 0x1B; then push+pop at full, flush and palette change
    begin : line_test
      int pushed, nx, dones;
      do_reset();
      bgp = 8'h1B; scx_fine = 3'd0;
      prefill(16, 0);
      pushed = 16; nx = 0; dones = 0;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        bus.bg_push_en = (cyc < 160);
        bus.bg_push_px.color = 2'(pushed % 4);
        tick();
        if (bus.bg_push_en) pushed++;
        if (pixel_valid) begin
          chk("line x", int'(pixel_x), nx);
          chk("line shade", int'(pixel_shade), 3 - (nx % 4));
          nx++;
        end
        if (line_done) begin
          dones++;
          chk("line_done position", nx, 160);
        end
      end
      bus.bg_push_en = 1'b0;
      chk("line strobes", nx, 160);
      chk("line_done count", dones, 1);
      chk("post-line count", int'(bus.fifo_count), 16);
      chk("post-line full", int'(bus.bg_fifo_full), 1);

      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      bus.bg_push_en = 1'b1; bus.bg_push_px.color = 2'(pushed % 4);
      tick();
      bus.bg_push_en = 1'b0;
      chk("full push+pop count", int'(bus.fifo_count), 16);
      chk("full push+pop full", int'(bus.bg_fifo_full), 1);
      chk("full push+pop valid", int'(pixel_valid), 1);
      chk("full push+pop x", int'(pixel_x), 0);
      chk("full push+pop shade", int'(pixel_shade), 3);
      for (int k = 1; k < 8; k++) begin
        tick();
        chk("drain x", int'(pixel_x), k);
        chk("drain shade", int'(pixel_shade), 3 - (k % 4));
      end
      chk("pre-flush count", int'(bus.fifo_count), 9);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush count", int'(bus.fifo_count), 0);
      chk("flush empty", int'(bus.bg_fifo_empty), 1);
      chk("flush valid", int'(pixel_valid), 0);
      bgp = 8'hE4;
      bus.bg_push_en = 1'b1; bus.bg_push_px.color = 2'd2;
      tick();
      bus.bg_push_en = 1'b0;
      chk("after flush no fallthrough", int'(pixel_valid), 0);
      tick();
      chk("after flush valid", int'(pixel_valid), 1);
      chk("after flush x", int'(pixel_x), 8);
      chk("after flush new bgp shade", int'(pixel_shade), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
